// File: rtl/seg7_scan_dev.sv
// seg7_scan_dev: memory-mapped multiplexed seven-segment display controller.
//
// Ports
//   clk, rst            system clock; asynchronous active-low reset
//   Addr[1:0]           word offset: 0 DATA, 1 DP, 2 CTRL, 3 STAT
//   We, BE[3:0], WD     single-cycle write strobe, byte enables, write data
//   RD[31:0]            combinational read data for Addr
//   IRQ                 level interrupt, CTRL.IE & STAT.FD
//   seg7_seg[7:0]       registered segment pins, [7]=dp, [6:0]=g..a
//   seg7_select[D-1:0]  registered one-hot digit select pins
//
// Each digit has its own decode lane; the scan index muxes one lane onto
// the pins through a single output register stage.

// Per-digit decode: hex nibble to active-high segments, with blanking.
// Blanking clears only g..a so a lit decimal point survives.
module seg7_digit_lane (
  input  logic [3:0] nib,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);
  logic [6:0] hex;

  always_comb begin
    hex = 7'h00;
    case (nib)
      4'h0: hex = 7'h3F;
      4'h1: hex = 7'h06;
      4'h2: hex = 7'h5B;
      4'h3: hex = 7'h4F;
      4'h4: hex = 7'h66;
      4'h5: hex = 7'h6D;
      4'h6: hex = 7'h7D;
      4'h7: hex = 7'h07;
      4'h8: hex = 7'h7F;
      4'h9: hex = 7'h6F;
      4'hA: hex = 7'h77;
      4'hB: hex = 7'h7C;
      4'hC: hex = 7'h39;
      4'hD: hex = 7'h5E;
      4'hE: hex = 7'h79;
      4'hF: hex = 7'h71;
      default: hex = 7'h00;
    endcase
  end

  assign seg = {dp, blank ? 7'h00 : hex};
endmodule

module seg7_scan_dev #(
  parameter int DIGITS         = 8,
  parameter int CLK_DIV        = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        Addr,
  input  logic              We,
  input  logic [3:0]        BE,
  input  logic [31:0]       WD,
  output logic [31:0]       RD,
  output logic              IRQ,
  output logic [7:0]        seg7_seg,
  output logic [DIGITS-1:0] seg7_select
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int NB = 4 * DIGITS;
  // Pin value when nothing is driven; XOR with it applies pin polarity.
  localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : '0;

  logic [NB-1:0]     data_q;
  logic [DIGITS-1:0] dp_q;
  logic [2:0]        ctrl_q;   // [0] EN, [1] LZB, [2] IE
  logic              fd_q;
  logic [DW-1:0]     div_q;
  logic [IW-1:0]     idx_q;

  logic en, lzb, ie;
  logic div_tc, frame_wrap;
  logic wr_data, wr_dp, wr_ctrl, wr_stat;
  logic [DIGITS-1:0][7:0] lane_seg;

  assign en  = ctrl_q[0];
  assign lzb = ctrl_q[1];
  assign ie  = ctrl_q[2];

  assign wr_data = We && (Addr == 2'd0);
  assign wr_dp   = We && (Addr == 2'd1) && BE[0];
  assign wr_ctrl = We && (Addr == 2'd2) && BE[0];
  assign wr_stat = We && (Addr == 2'd3) && BE[0];

  // Write-data bits above the implemented fields are deliberately dropped.
  logic unused_wd;
  assign unused_wd = ^WD;

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      dp_q   <= '0;
      ctrl_q <= '0;
      fd_q   <= 1'b0;
    end else begin
      if (wr_data)
        for (int b = 0; b < NB; b++)
          if (BE[b/8]) data_q[b] <= WD[b];
      if (wr_dp)   dp_q   <= WD[DIGITS-1:0];
      if (wr_ctrl) ctrl_q <= WD[2:0];
      // A wrap in the same cycle as a W1C keeps FD set.
      if (frame_wrap)             fd_q <= 1'b1;
      else if (wr_stat && WD[0])  fd_q <= 1'b0;
    end
  end

  always_comb begin
    RD = '0;
    case (Addr)
      2'd0: RD[NB-1:0]     = data_q;
      2'd1: RD[DIGITS-1:0] = dp_q;
      2'd2: RD[2:0]        = ctrl_q;
      2'd3: RD[0]          = fd_q;
      default: RD = '0;
    endcase
  end

  assign IRQ = ie & fd_q;

  // ---------------- scan engine ----------------
  assign div_tc     = (div_q == DW'(CLK_DIV - 1));
  assign frame_wrap = en && div_tc && (idx_q == IW'(DIGITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (!en) begin
      // Disabled: hold at the frame start so re-enable begins at digit 0.
      div_q <= '0;
      idx_q <= '0;
    end else if (div_tc) begin
      div_q <= '0;
      idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  // ---------------- per-digit decode lanes ----------------
  for (genvar i = 0; i < DIGITS; i++) begin : g_lane
    logic blank;
    if (i == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_hi
      // Blank when this digit and every digit above it are zero.
      assign blank = lzb && (data_q[NB-1:4*i] == '0);
    end
    seg7_digit_lane u_lane (
      .nib   (data_q[4*i +: 4]),
      .dp    (dp_q[i]),
      .blank (blank),
      .seg   (lane_seg[i])
    );
  end

  // ---------------- output pins ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg7_seg    <= SEG_OFF;
      seg7_select <= SEL_OFF;
    end else if (!en) begin
      seg7_seg    <= SEG_OFF;
      seg7_select <= SEL_OFF;
    end else begin
      seg7_seg    <= lane_seg[idx_q] ^ SEG_OFF;
      seg7_select <= (DIGITS'(1) << idx_q) ^ SEL_OFF;
    end
  end
endmodule
